fft_frame_sequencer: RTL and testbench

- Parametrised successor to the single-channel FFT/LCD frame controller.
- Sequences capture -> FFT -> LCD draw -> hold for one or more ADC channels, selected round-robin.
- Writes N_POINTS samples into the FFT input buffer, pulses FFT and draw starts, and enforces a refresh interval.
- Adds run/single-shot modes and watchdog timeouts; sits between the ADC filter path, the FFT core and the LCD spectrum drawer.

---
 rtl/fft_frame_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer: capture N_POINTS samples -> FFT -> LCD draw -> hold, round-robin over channels.
// Define FFT_SEQ_TRIGGER_EN to add a rising-edge trigger (trig_level) that arms each capture.
module fft_frame_sequencer #(
   parameter int DATA_W         = 8,
   parameter int N_POINTS       = 1024,
   parameter int NUM_CH         = 1,
   parameter int HOLD_CYCLES    = 100000,
   parameter int TIMEOUT_CYCLES = 1048576,
   localparam int ADDR_W        = $clog2(N_POINTS),
   localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              single,
   input  logic              ad_valid,
   input  logic [DATA_W-1:0] ad_data,
`ifdef FFT_SEQ_TRIGGER_EN
   input  logic [DATA_W-1:0] trig_level,
`endif
   input  logic              fft_over,
   input  logic              lcd_draw_over,
   output logic              capture_we,
   output logic [ADDR_W-1:0] capture_addr,
   output logic [DATA_W-1:0] capture_data,
   output logic [CH_W-1:0]   ch_sel,
   output logic              fft_start,
   output logic              draw_start,
   output logic              busy,
   output logic              timeout_err,
   output logic [15:0]       frame_cnt
);

   // One shared timer serves the FFT/DRAW watchdog, the hold interval and the arm timeout.
   localparam int TMR_MAX      = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
   localparam int TMR_W        = $clog2(TMR_MAX + 1);
   localparam int TIMEOUT_LAST = TIMEOUT_CYCLES - 1;
   localparam int HOLD_LAST    = (HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1;

   typedef enum logic [2:0] {IDLE, CAPTURE, START, FFT, DRAW, HOLD} state_t;

   state_t            state, state_n;
   logic [TMR_W-1:0]  tmr, tmr_n;
   logic [ADDR_W:0]   cnt, cnt_n;
   logic              take;
   logic              fft_start_n, draw_start_n;
   logic              timeout_n;
   logic [15:0]       frame_cnt_n;
   logic [CH_W-1:0]   ch_sel_n;
   logic              single_flag, single_flag_n;

`ifdef FFT_SEQ_TRIGGER_EN
   logic              arming, arming_n;
   logic              prev_seen, prev_seen_n;
   logic [DATA_W-1:0] prev_sample;
`endif

   always_comb begin
      state_n       = state;
      tmr_n         = tmr + 1'b1;
      cnt_n         = cnt;
      take          = 1'b0;
      fft_start_n   = 1'b0;
      draw_start_n  = 1'b0;
      timeout_n     = timeout_err;
      frame_cnt_n   = frame_cnt;
      ch_sel_n      = ch_sel;
      single_flag_n = single_flag;
`ifdef FFT_SEQ_TRIGGER_EN
      arming_n      = arming;
      prev_seen_n   = prev_seen;
`endif
      case (state)
         IDLE: begin
            if (run || single) begin
               state_n       = CAPTURE;
               single_flag_n = single;
            end
         end
         CAPTURE: begin
            // cnt[ADDR_W] marks that the last buffer write is already on the outputs
            if (cnt[ADDR_W]) begin
               state_n     = START;
               fft_start_n = 1'b1;
            end
`ifdef FFT_SEQ_TRIGGER_EN
            else if (arming) begin
               if (ad_valid) begin
                  prev_seen_n = 1'b1;
                  if (prev_seen && (prev_sample < trig_level) && (ad_data >= trig_level)) begin
                     take     = 1'b1;
                     arming_n = 1'b0;
                  end
               end
               if (tmr == TMR_W'(TIMEOUT_LAST)) arming_n = 1'b0;
            end
`endif
            else if (ad_valid) begin
               take = 1'b1;
            end
         end
         START: state_n = FFT;
         FFT: begin
            if (fft_over) begin
               state_n      = DRAW;
               draw_start_n = 1'b1;
            end else if (tmr == TMR_W'(TIMEOUT_LAST)) begin
               state_n   = HOLD;
               timeout_n = 1'b1;
            end
         end
         DRAW: begin
            if (lcd_draw_over) begin
               state_n     = HOLD;
               frame_cnt_n = frame_cnt + 16'd1;
            end else if (tmr == TMR_W'(TIMEOUT_LAST)) begin
               state_n   = HOLD;
               timeout_n = 1'b1;
            end
         end
         HOLD: begin
            if (tmr == TMR_W'(HOLD_LAST)) begin
               ch_sel_n = (ch_sel == CH_W'(NUM_CH - 1)) ? '0 : ch_sel + 1'b1;
               if (run) begin
                  state_n = CAPTURE;
               end else begin
                  state_n       = IDLE;
                  single_flag_n = 1'b0;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      if (take) cnt_n = cnt + 1'b1;
      if (state_n != state) tmr_n = '0;
      if ((state_n == CAPTURE) && (state != CAPTURE)) begin
         cnt_n = '0;
`ifdef FFT_SEQ_TRIGGER_EN
         arming_n    = 1'b1;
         prev_seen_n = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         tmr          <= '0;
         cnt          <= '0;
         single_flag  <= 1'b0;
         capture_we   <= 1'b0;
         capture_addr <= '0;
         capture_data <= '0;
         ch_sel       <= '0;
         fft_start    <= 1'b0;
         draw_start   <= 1'b0;
         busy         <= 1'b0;
         timeout_err  <= 1'b0;
         frame_cnt    <= '0;
`ifdef FFT_SEQ_TRIGGER_EN
         arming       <= 1'b0;
         prev_seen    <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         tmr         <= tmr_n;
         cnt         <= cnt_n;
         single_flag <= single_flag_n;
         capture_we  <= take;
         if (take) begin
            capture_addr <= cnt[ADDR_W-1:0];
            capture_data <= ad_data;
         end
         ch_sel      <= ch_sel_n;
         fft_start   <= fft_start_n;
         draw_start  <= draw_start_n;
         busy        <= (state_n != IDLE);
         timeout_err <= timeout_n;
         frame_cnt   <= frame_cnt_n;
`ifdef FFT_SEQ_TRIGGER_EN
         arming      <= arming_n;
         prev_seen   <= prev_seen_n;
`endif
      end
   end

`ifdef FFT_SEQ_TRIGGER_EN
   always_ff @(posedge clk) begin
      if ((state == CAPTURE) && ad_valid) prev_sample <= ad_data;
   end
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer: expected writes/pulses queued by stimulus, checked by a monitor.
module tb_fft_frame_sequencer;

   localparam int HOLD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic       single = 1'b0;
   logic       ad_valid = 1'b0;
   logic [7:0] ad_data = 8'h00;
   logic       fft_over = 1'b0;
   logic       lcd_draw_over = 1'b0;
`ifdef FFT_SEQ_TRIGGER_EN
   logic [7:0] trig_level = 8'd100;
`endif
   logic       capture_we;
   logic [2:0] capture_addr;
   logic [7:0] capture_data;
   logic [1:0] ch_sel;
   logic       fft_start;
   logic       draw_start;
   logic       busy;
   logic       timeout_err;
   logic [15:0] frame_cnt;

   int  n_checks = 0;
   int  n_errors = 0;
   bit  fft_en = 1'b1;
   bit  draw_en = 1'b1;
   int  fft_delay = 5;

   localparam int EV_W = 0, EV_F = 1, EV_D = 2;
   typedef struct {int kind; int addr; int data; int ch;} ev_t;
   ev_t exp_q[$];

   fft_frame_sequencer #(
      .DATA_W(8), .N_POINTS(8), .NUM_CH(3), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(16)
   ) dut (
`ifdef FFT_SEQ_TRIGGER_EN
      .trig_level(trig_level),
`endif
      .clk(clk), .rst(rst), .run(run), .single(single),
      .ad_valid(ad_valid), .ad_data(ad_data),
      .fft_over(fft_over), .lcd_draw_over(lcd_draw_over),
      .capture_we(capture_we), .capture_addr(capture_addr), .capture_data(capture_data),
      .ch_sel(ch_sel), .fft_start(fft_start), .draw_start(draw_start),
      .busy(busy), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_ctrl"},  {capture_we, fft_start, draw_start, timeout_err}, 0);
      check({tag, "_addr"},  capture_addr, 0);
      check({tag, "_data"},  capture_data, 0);
      check({tag, "_ch"},    ch_sel, 0);
      check({tag, "_frame"}, frame_cnt, 0);
   endtask

   task automatic push_ev(input int kind, input int addr, input int data, input int ch);
      ev_t e;
      e.kind = kind; e.addr = addr; e.data = data; e.ch = ch;
      exp_q.push_back(e);
   endtask

   // Eight writes of base + i*step at addresses 0..7, then the FFT start and optionally the draw start.
   task automatic expect_frame(input int ch, input logic [7:0] base, input int stp, input bit with_draw);
      for (int i = 0; i < 8; i++) begin
         logic [7:0] v;
         v = base + 8'(i * stp);
         push_ev(EV_W, i, int'(v), ch);
      end
      push_ev(EV_F, 0, 0, ch);
      if (with_draw) push_ev(EV_D, 0, 0, ch);
   endtask

   task automatic send_samples(input logic [7:0] base, input int stp, input bit gaps);
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         ad_valid = 1'b1;
         ad_data  = base + 8'(i * stp);
         @(posedge clk); #1;
         ad_valid = 1'b0;
         ad_data  = 8'hEE;
         if (gaps) begin @(posedge clk); #1; end
      end
   endtask

   task automatic wait_frame(input int n);
      int k = 0;
      do begin @(negedge clk); k++; end while (frame_cnt != 16'(n) && k < 400);
      check("frame_cnt", frame_cnt, n);
   endtask

   // Cycles from the frame_cnt update (first HOLD cycle) to the ch_sel advance on leaving HOLD.
   task automatic measure_hold(input logic [1:0] ch_before);
      int k = 0;
      do begin @(negedge clk); k++; end while (ch_sel == ch_before && k < 50);
      check("hold_len", k, HOLD);
   endtask

   task automatic check_ev(input int kind);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL unexpected_event: got kind %0d, expected none at %0t", kind, $time);
      end else begin
         e = exp_q.pop_front();
         check("ev_kind", kind, e.kind);
         check("ev_ch", ch_sel, e.ch);
         if (kind == EV_W && e.kind == EV_W) begin
            check("wr_addr", capture_addr, e.addr);
            check("wr_data", capture_data, e.data);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (capture_we) check_ev(EV_W);
         if (fft_start)  check_ev(EV_F);
         if (draw_start) check_ev(EV_D);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (fft_start && fft_en) begin
            repeat (fft_delay) @(posedge clk);
            #1 fft_over = 1'b1;
            @(posedge clk);
            #1 fft_over = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (draw_start && draw_en) begin
            repeat (3) @(posedge clk);
            #1 lcd_draw_over = 1'b1;
            @(posedge clk);
            #1 lcd_draw_over = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
      $fatal(1, "bench time limit");
   end

   initial begin
      int k;
      step(3);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1 rst = 1'b0;
      step(2);
      check("idle_busy", busy, 0);

`ifdef FFT_SEQ_TRIGGER_EN
      // Ramp 90,95,99,101,103.. : 101 is the first sample at/above 100 after one below it.
      push_ev(EV_W, 0, 101, 0);
      for (int i = 1; i < 8; i++) push_ev(EV_W, i, 101 + 2 * i, 0);
      push_ev(EV_F, 0, 0, 0);
      push_ev(EV_D, 0, 0, 0);
      run = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 11; i++) begin
         ad_valid = 1'b1;
         ad_data  = (i == 0) ? 8'd90 : (i == 1) ? 8'd95 : (i == 2) ? 8'd99 : 8'(101 + 2 * (i - 3));
         @(posedge clk); #1;
      end
      ad_valid = 1'b0;
      run = 1'b0;
      wait_frame(1);
`else
      // Continuous run, one sample per clock, channel 0.
      run = 1'b1;
      expect_frame(0, 8'h00, 1, 1);
      send_samples(8'h00, 1, 1'b0);
      wait_frame(1);
      measure_hold(2'd0);

      // Samples on alternate cycles with junk data in the gaps, channel 1.
      expect_frame(1, 8'h10, 3, 1);
      send_samples(8'h10, 3, 1'b1);
      wait_frame(2);
      measure_hold(2'd1);

      // Channel 2, data wrapping through 0xFF.
      expect_frame(2, 8'hF8, 1, 1);
      send_samples(8'hF8, 1, 1'b0);
      wait_frame(3);
      measure_hold(2'd2);

      // Channel wraps to 0; fft_over lands on the watchdog's last cycle; run drops mid-frame.
      fft_delay = 16;
      expect_frame(0, 8'h5A, 7, 1);
      send_samples(8'h5A, 7, 1'b0);
      run = 1'b0;
      wait_frame(4);
      measure_hold(2'd0);
      check("run_drop_busy", busy, 0);
      check("race_timeout_err", timeout_err, 0);
      check("race_ch_sel", ch_sel, 1);
      fft_delay = 5;

      // FFT never completes: watchdog fires 16 cycles after FFT entry, no draw.
      fft_en = 1'b0;
      run = 1'b1;
      expect_frame(1, 8'h33, 1, 0);
      send_samples(8'h33, 1, 1'b0);
      run = 1'b0;
      k = 0;
      do begin @(negedge clk); k++; end while (!fft_start && k < 100);
      check("to_fft_start_seen", fft_start, 1);
      k = 0;
      do begin @(negedge clk); k++; end while (!timeout_err && k < 40);
      check("timeout_latency", k, 17);
      k = 0;
      do begin @(negedge clk); k++; end while (busy && k < 40);
      check("to_idle_busy", busy, 0);
      check("to_frame_cnt", frame_cnt, 4);
      check("to_ch_sel", ch_sel, 2);
      fft_en = 1'b1;

      // Single shot; a second single pulse mid-frame is ignored.
      expect_frame(2, 8'hC0, 2, 1);
      single = 1'b1;
      @(posedge clk); #1 single = 1'b0;
      send_samples(8'hC0, 2, 1'b0);
      single = 1'b1;
      @(posedge clk); #1 single = 1'b0;
      wait_frame(5);
      measure_hold(2'd2);
      check("single_busy_drop", busy, 0);
      step(20);
      check("single_one_frame", frame_cnt, 5);
      check("single_still_idle", busy, 0);
      check("timeout_sticky", timeout_err, 1);

      // Asynchronous reset while waiting in DRAW.
      draw_en = 1'b0;
      run = 1'b1;
      expect_frame(0, 8'h80, 1, 1);
      send_samples(8'h80, 1, 1'b0);
      k = 0;
      do begin @(negedge clk); k++; end while (!draw_start && k < 100);
      check("rst_draw_start_seen", draw_start, 1);
      step(2);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_all_zero("rst_mid_draw");
      run = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      step(3);
      check("post_rst_busy", busy, 0);
      check("post_rst_frame", frame_cnt, 0);
`endif

      check("pending_events", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
